mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter that shares the single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX issue / MEM `data_ok` completion path). Forwards one request per cycle, holds a grant until its address handshake completes, and records the source of every accepted request in an in-order tag FIFO. Each `mem_data_ok` response is routed back to the requester that issued it. Sits between the pipeline's `inst_sram_*` / `data_sram_*` interfaces and the memory-side bridge.

## Interface
- DEPTH, 4, maximum outstanding (accepted, not yet answered) requests; power of two, ≥2
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req / data_req  in  1  request valid, held until the matching addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_wstrb / data_wstrb  in  4  byte strobes
- inst_addr / data_addr  in  32  address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for that requester this cycle
- inst_rdata / data_rdata  out  32  copies of mem_rdata
- mem_req  out  1  forwarded request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  fields of the granted requester
- mem_addr_ok  in  1  downstream accepts mem_req
- mem_data_ok  in  1  downstream response, strictly in request order
- mem_rdata  in  32  response data

## Operation
- Source encoding: 0 = INST, 1 = DATA.
- State: lock_valid, lock_src; tag FIFO of DEPTH 1-bit entries (rd_ptr, wr_ptr, count of width log2(DEPTH)+1).
- Grant:
  - if lock_valid, grant = lock_src;
  - otherwise grant = DATA when data_req, else INST (fixed priority to DATA).
- mem_req = granted req & (count != DEPTH). All mem_* fields are a mux of the granted requester's fields, independent of mem_req.
- Accept = mem_req & mem_addr_ok. On accept:
  - only the granted requester's addr_ok = 1;
  - push grant into the FIFO;
  - clear lock_valid.
- Lock rule: if the granted req = 1 and no accept happens (mem_addr_ok low or FIFO full), set lock_valid = 1 and lock_src = grant. A pending request is never switched away from, and its fields stay stable downstream.
- If the locked requester drops req (after a pipeline flush), clear lock_valid next cycle. A request that was never accepted creates no FIFO entry.
- Response: when mem_data_ok = 1 and count != 0:
  - pop the head;
  - head INST: inst_data_ok = 1;
  - head DATA: data_data_ok = 1.
- mem_data_ok with count == 0 is a protocol error. Both data_ok outputs stay 0 and the FIFO is unchanged.
- Both rdata outputs always equal mem_rdata. Write responses pop the FIFO exactly like reads.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, push is blocked even if a pop occurs in the same cycle: mem_req is 0 whenever count == DEPTH at the start of the cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Fully combinational forwarding, zero added latency:
  - req → mem_req;
  - mem_addr_ok → x_addr_ok;
  - mem_data_ok → x_data_ok.
- FIFO, lock and count update on the rising clk edge.
- Reset (resetn = 0 at a clk edge) sets lock_valid = 0, lock_src = 0, rd_ptr = wr_ptr = count = 0.
- While resetn = 0, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0.
- Reset mid-operation discards all outstanding tags. The downstream bridge is reset by the same resetn.
- Throughput: one accept and one response per cycle.

## Test plan
- Priority: inst_req = data_req = 1 in the same cycle, mem_addr_ok = 1 → mem_addr = data_addr and data_addr_ok = 1. The next cycle grants INST → inst_addr_ok = 1.
- Lock: inst_req = 1 alone with mem_addr_ok = 0 for 3 cycles, data_req rises in cycle 2 → mem_addr stays inst_addr through all 3 cycles. When mem_addr_ok = 1, inst_addr_ok = 1. DATA is served the following cycle.
- Ordering: accept INST@0x1000, DATA@0x2000, INST@0x1004; return mem_data_ok with rdata 0xA, 0xB, 0xC → inst_data_ok / rdata 0xA, then data_data_ok / 0xB, then inst_data_ok / 0xC.
- Full (DEPTH = 4): 4 accepts with no responses, then data_req = 1 → mem_req = 0 and lock set. A response in the next cycle → count = 3, the following cycle mem_req = 1 with the locked DATA fields.
- Simultaneous push/pop at count = 2 → count stays 2. The popped response routes correctly and the new tag is appended at the tail.
- Reset mid-flight with 3 outstanding → after reset count = 0. A spurious mem_data_ok produces no data_ok outputs.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one SRAM-like port between instruction fetch and data access.
// Accepted request sources are queued in order so each response returns to its issuer.
module mem_port_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic          r_lockValid;
  src_e          r_lockSrc;
  src_e          r_fifo [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  src_e w_grant;
  src_e w_head;
  logic w_grantData;
  logic w_grantReq;
  logic w_full;
  logic w_accept;
  logic w_pop;

  // A pending (locked) request keeps the grant; otherwise DATA has fixed priority.
  always_comb begin
    w_grant = SRC_INST;
    if (r_lockValid)
      w_grant = r_lockSrc;
    else if (data_req)
      w_grant = SRC_DATA;
  end

  assign w_grantData = (w_grant == SRC_DATA);
  assign w_grantReq  = w_grantData ? data_req : inst_req;
  assign w_full      = (r_count == FULL_COUNT);
  assign w_head      = r_fifo[r_rdPtr];

  assign mem_req   = resetn & w_grantReq & ~w_full;
  assign mem_wr    = w_grantData ? data_wr    : inst_wr;
  assign mem_size  = w_grantData ? data_size  : inst_size;
  assign mem_wstrb = w_grantData ? data_wstrb : inst_wstrb;
  assign mem_addr  = w_grantData ? data_addr  : inst_addr;
  assign mem_wdata = w_grantData ? data_wdata : inst_wdata;

  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & ~w_grantData;
  assign data_addr_ok = w_accept &  w_grantData;

  // Responses with nothing outstanding are ignored rather than misrouted.
  assign w_pop        = resetn & mem_data_ok & (r_count != '0);
  assign inst_data_ok = w_pop & (w_head == SRC_INST);
  assign data_data_ok = w_pop & (w_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lockValid <= 1'b0;
      r_lockSrc   <= SRC_INST;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
    end else begin
      r_lockValid <= w_grantReq & ~w_accept;
      if (w_grantReq & ~w_accept)
        r_lockSrc <= w_grant;
      if (w_accept)
        r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
    end
  end

  // Tag storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_fifo[r_wrPtr] <= w_grant;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: priority, locking, ordering,
// full-FIFO blocking, simultaneous push/pop and reset behaviour.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int errors;
  int checks;

  mem_port_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge and are observed 1ns later.
  task automatic applyStimulus(input logic ir, input logic dr, input logic aok,
                               input logic dok, input logic [31:0] rdata);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic isData);
    applyStimulus(~isData, isData, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_memReq: got %b want 0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("[TB] FAIL rst_addrOk: got %b want 00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL rst_dataOk: got %b want 00", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'hDEAD_BEEF || data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rst_rdata: got %h/%h want deadbeef", inst_rdata, data_rdata); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    resetn = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_idleReq: got %b want 0", mem_req); end
  endtask

  task automatic test_priority();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_addr !== 32'h2000) begin errors++; $display("[TB] FAIL prio_addr: got %h want 2000", mem_addr); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL prio_dataOk: got %b want 01", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_wr !== 1'b1 || mem_size !== 2'd2 || mem_wstrb !== 4'hF || mem_wdata !== 32'hCAFE_0002) begin errors++; $display("[TB] FAIL prio_fields: got %b %0d %h %h want 1 2 f cafe0002", mem_wr, mem_size, mem_wstrb, mem_wdata); end
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_addr !== 32'h1000 || mem_size !== 2'd1) begin errors++; $display("[TB] FAIL prio_inst: got %h size %0d want 1000 size 1", mem_addr, mem_size); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL prio_instOk: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h55) begin errors++; $display("[TB] FAIL prio_resp0: got %b %h want 01 55", {inst_data_ok, data_data_ok}, data_rdata); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h66);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h66) begin errors++; $display("[TB] FAIL prio_resp1: got %b %h want 10 66", {inst_data_ok, data_data_ok}, inst_rdata); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_lock();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL lock_c1: got %b %h want 1 1000", mem_req, mem_addr); end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL lock_c2: got %h want 1000", mem_addr); end
    tick();
    checks++; if (mem_addr !== 32'h1000 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL lock_c3: got %h %b want 1000 0", mem_addr, inst_addr_ok); end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL lock_acc: got %b %h want 10 1000", {inst_addr_ok, data_addr_ok}, mem_addr); end
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01 || mem_addr !== 32'h2000) begin errors++; $display("[TB] FAIL lock_next: got %b %h want 01 2000", {inst_addr_ok, data_addr_ok}, mem_addr); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL lock_resp0: got %b want 10", {inst_data_ok, data_data_ok}); end
    tick();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("[TB] FAIL lock_resp1: got %b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL flush_drop: got %b %h want 0 1000", mem_req, mem_addr); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("[TB] FAIL flush_free: got %b %h want 1 2000", mem_req, mem_addr); end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("[TB] FAIL flush_resp: got %b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_ordering();
    logic [31:0] rd [3];
    logic [1:0]  ok [3];
    rd = '{32'hA, 32'hB, 32'hC};
    ok = '{2'b10, 2'b01, 2'b10};
    inst_addr = 32'h1000;
    pushOne(1'b0);
    pushOne(1'b1);
    inst_addr = 32'h1004;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_addr !== 32'h1004 || inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL ord_push3: got %h %b want 1004 1", mem_addr, inst_addr_ok); end
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, rd[i]);
      checks++; if ({inst_data_ok, data_data_ok} !== ok[i]) begin errors++; $display("[TB] FAIL ord_route%0d: got %b want %b", i, {inst_data_ok, data_data_ok}, ok[i]); end
      checks++; if ((ok[i][1] ? inst_rdata : data_rdata) !== rd[i]) begin errors++; $display("[TB] FAIL ord_rdata%0d: got %h want %h", i, ok[i][1] ? inst_rdata : data_rdata, rd[i]); end
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    inst_addr = 32'h1000;
  endtask

  task automatic test_full();
    logic [1:0] ok [4];
    ok = '{2'b10, 2'b01, 2'b10, 2'b01};
    pushOne(1'b0);
    pushOne(1'b0);
    pushOne(1'b1);
    pushOne(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL full_block: got %b %b want 0 0", mem_req, data_addr_ok); end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h7);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_popCycle: got %b want 0", mem_req); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL full_pop: got %b want 10", {inst_data_ok, data_data_ok}); end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || {inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL full_resume: got %b %h %b want 1 2000 01", mem_req, mem_addr, {inst_addr_ok, data_addr_ok}); end
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_again: got %b want 0", mem_req); end
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      checks++; if ({inst_data_ok, data_data_ok} !== ok[i]) begin errors++; $display("[TB] FAIL full_drain%0d: got %b want %b", i, {inst_data_ok, data_data_ok}, ok[i]); end
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ok [4];
    ok = '{2'b10, 2'b01, 2'b10, 2'b01};
    pushOne(1'b1);
    pushOne(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h77) begin errors++; $display("[TB] FAIL b2b_pop0: got %b %h want 01 77", {inst_data_ok, data_data_ok}, data_rdata); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_push0: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h88);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || {inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_pop1: got %b %b want 10 01", {inst_data_ok, data_data_ok}, {inst_addr_ok, data_addr_ok}); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pushOne(1'b0);
    pushOne(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_count: got %b want 0", mem_req); end
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      checks++; if ({inst_data_ok, data_data_ok} !== ok[i]) begin errors++; $display("[TB] FAIL b2b_drain%0d: got %b want %b", i, {inst_data_ok, data_data_ok}, ok[i]); end
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    pushOne(1'b0);
    pushOne(1'b1);
    pushOne(1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL mid_spurious: got %b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    pushOne(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("[TB] FAIL mid_fresh: got %b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd1; inst_wstrb = 4'h3;
    inst_addr = 32'h1000; inst_wdata = 32'hCAFE_0001;
    data_req = 1'b0; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h2000; data_wdata = 32'hCAFE_0002;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    #1;
    test_reset();
    test_priority();
    test_lock();
    test_flush();
    test_ordering();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
